// File: rtl/assoc_cache.sv
// assoc_cache: write-through, write-allocate cache (direct-mapped or 2-way LRU)
// with an integrated block-fill engine and saturating hit/miss counters.
module assoc_cache #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned INDEX_W  = 7,
    parameter int unsigned OFFSET_W = 3,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned TAG_W = ADDR_W - 1 - INDEX_W - OFFSET_W;
    localparam int unsigned SETS  = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFSET_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Storage is sized for two ways; way 1 is never hit or chosen when WAYS=1.
    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_mem  [2][SETS];
    logic [DATA_W-1:0]    data_mem [2][SETS][WORDS];

    state_t               state_q;
    logic [TAG_W-1:0]     blk_tag_q;
    logic [INDEX_W-1:0]   blk_idx_q;
    logic                 victim_q;
    logic [OFFSET_W-1:0]  issue_cnt_q;
    logic                 issue_done_q;
    logic [OFFSET_W-1:0]  recv_cnt_q;
    logic                 replay_q;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_idx;
    logic [OFFSET_W-1:0]  req_off;
    logic [1:0]           way_hit;
    logic                 hit;
    logic                 hit_way;
    logic                 victim;
    logic                 in_fill;
    logic                 req_hit;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 miss;
    logic                 fill_wr;
    logic                 last_word;

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr[OFFSET_W+1 +: INDEX_W];
    assign req_off = req_addr[OFFSET_W:1];

    // Tag compare for both ways of the addressed set.
    always_comb begin
        way_hit    = 2'b00;
        way_hit[0] = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
        way_hit[1] = (WAYS == 2) && valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    // Victim: first invalid way, else the LRU way; always way 0 when direct-mapped.
    always_comb begin
        victim = 1'b0;
        if ((WAYS == 2) && valid_q[0][req_idx]) begin
            victim = valid_q[1][req_idx] ? lru_q[req_idx] : 1'b1;
        end
    end

    assign in_fill   = (state_q == FILL);
    assign req_hit   = (state_q == IDLE) && req_valid && hit;
    assign rd_hit    = req_hit && !req_wr;
    assign wr_hit    = req_hit && req_wr;
    assign miss      = (state_q == IDLE) && req_valid && !hit;
    assign fill_wr   = rst && in_fill && mem_data_valid;
    assign last_word = (recv_cnt_q == OFFSET_W'(WORDS - 1));

    // Combinational outputs, forced to zero while reset is asserted.
    always_comb begin
        rdata      = '0;
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (rst) begin
            stall = miss || in_fill;
            if (rd_hit) begin
                rdata = data_mem[hit_way][req_idx][req_off];
            end
            if (in_fill && !issue_done_q) begin
                mem_rd_req = 1'b1;
                mem_addr   = {blk_tag_q, blk_idx_q, issue_cnt_q, 1'b0};
            end else if (wr_hit) begin
                mem_wr_req = 1'b1;
                mem_addr   = req_addr;
                mem_wdata  = req_wdata;
            end
        end
    end

    // Control FSM, fill counters, valid/LRU bits and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            blk_tag_q    <= '0;
            blk_idx_q    <= '0;
            victim_q     <= 1'b0;
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b0;
            recv_cnt_q   <= '0;
            replay_q     <= 1'b0;
            valid_q      <= '0;
            lru_q        <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            replay_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (hit) begin
                            if (WAYS == 2) begin
                                lru_q[req_idx] <= ~hit_way;
                            end
                            if (!replay_q && (hit_count != '1)) begin
                                hit_count <= hit_count + 1'b1;
                            end
                        end else begin
                            state_q      <= FILL;
                            blk_tag_q    <= req_tag;
                            blk_idx_q    <= req_idx;
                            victim_q     <= victim;
                            issue_cnt_q  <= '0;
                            issue_done_q <= 1'b0;
                            recv_cnt_q   <= '0;
                            if (miss_count != '1) begin
                                miss_count <= miss_count + 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (!issue_done_q) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                        if (issue_cnt_q == OFFSET_W'(WORDS - 1)) begin
                            issue_done_q <= 1'b1;
                        end
                    end
                    if (mem_data_valid) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                        if (last_word) begin
                            valid_q[victim_q][blk_idx_q] <= 1'b1;
                            if (WAYS == 2) begin
                                lru_q[blk_idx_q] <= ~victim_q;
                            end
                            state_q  <= IDLE;
                            replay_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: fill writes and write-hit updates.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_mem[victim_q][blk_idx_q][recv_cnt_q] <= mem_rdata;
            if (last_word) begin
                tag_mem[victim_q][blk_idx_q] <= blk_tag_q;
            end
        end
        if (rst && wr_hit) begin
            data_mem[hit_way][req_idx][req_off] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed scoreboard bench for assoc_cache (2-way and direct-mapped).
module tb_assoc_cache;

    localparam int unsigned MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        use_dm = 1'b0;

    logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_hit, a_miss;
    logic        a_stall, a_mem_rd_req, a_mem_wr_req, a_mem_data_valid;
    logic [15:0] d_rdata, d_mem_addr, d_mem_wdata, d_mem_rdata, d_hit, d_miss;
    logic        d_stall, d_mem_rd_req, d_mem_wr_req, d_mem_data_valid;

    logic [16:0] a_pipe [MEM_LAT] = '{default: '0};
    logic [16:0] d_pipe [MEM_LAT] = '{default: '0};

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    logic [15:0] rd_q [$];
    logic [15:0] addr_q [$];

    always #5 clk = ~clk;

    assoc_cache u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(a_rdata), .stall(a_stall),
        .mem_rd_req(a_mem_rd_req), .mem_wr_req(a_mem_wr_req), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_data_valid(a_mem_data_valid), .mem_rdata(a_mem_rdata),
        .hit_count(a_hit), .miss_count(a_miss)
    );

    assoc_cache #(.WAYS(1)) u_dm (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(d_rdata), .stall(d_stall),
        .mem_rd_req(d_mem_rd_req), .mem_wr_req(d_mem_wr_req), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_data_valid(d_mem_data_valid), .mem_rdata(d_mem_rdata),
        .hit_count(d_hit), .miss_count(d_miss)
    );

    // Memory models: data = word address, returned MEM_LAT cycles after the request.
    always @(posedge clk) begin
        a_pipe[0] <= {a_mem_rd_req, a_mem_addr};
        d_pipe[0] <= {d_mem_rd_req, d_mem_addr};
        for (int i = 1; i < MEM_LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            d_pipe[i] <= d_pipe[i-1];
        end
    end
    assign a_mem_data_valid = a_pipe[MEM_LAT-1][16];
    assign a_mem_rdata      = a_pipe[MEM_LAT-1][15:0];
    assign d_mem_data_valid = d_pipe[MEM_LAT-1][16];
    assign d_mem_rdata      = d_pipe[MEM_LAT-1][15:0];

    // Observed instance selection.
    wire [15:0] o_rdata     = use_dm ? d_rdata      : a_rdata;
    wire        o_stall     = use_dm ? d_stall      : a_stall;
    wire        o_rd_req    = use_dm ? d_mem_rd_req : a_mem_rd_req;
    wire        o_wr_req    = use_dm ? d_mem_wr_req : a_mem_wr_req;
    wire [15:0] o_mem_addr  = use_dm ? d_mem_addr   : a_mem_addr;
    wire [15:0] o_mem_wdata = use_dm ? d_mem_wdata  : a_mem_wdata;
    wire        o_dvalid    = use_dm ? d_mem_data_valid : a_mem_data_valid;
    wire [15:0] o_hit       = use_dm ? d_hit        : a_hit;
    wire [15:0] o_miss      = use_dm ? d_miss       : a_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag, input logic [15:0] h, input logic [15:0] m);
        chk({tag, "_hit_count"}, 32'(o_hit), 32'(h));
        chk({tag, "_miss_count"}, 32'(o_miss), 32'(m));
    endtask

    // One processor access, held until stall drops; checks fill addresses and the completion cycle.
    task automatic access(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp, input bit miss,
                          input int exp_stalls);
        int stalls;
        stalls = 0;
        if (miss) begin
            for (int i = 0; i < 8; i++) addr_q.push_back({addr[15:4], 3'(i), 1'b0});
        end
        if (!wr) rd_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
        #1;
        while (o_stall === 1'b1 && stalls < 100) begin
            if (o_rd_req === 1'b1) begin
                if (addr_q.size() == 0) chk({tag, "_extra_rd_req"}, 32'(o_rd_req), 32'd0);
                else chk({tag, "_fill_addr"}, 32'(o_mem_addr), 32'(addr_q.pop_front()));
            end
            chk({tag, "_no_wr_in_stall"}, 32'(o_wr_req), 32'd0);
            stalls++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, "_fill_reqs_left"}, 32'(addr_q.size()), 32'd0);
        addr_q.delete();
        chk({tag, "_no_rd_req"}, 32'(o_rd_req), 32'd0);
        if (wr) begin
            chk({tag, "_wr_req"}, 32'(o_wr_req), 32'd1);
            chk({tag, "_wr_addr"}, 32'(o_mem_addr), 32'(addr));
            chk({tag, "_wr_data"}, 32'(o_mem_wdata), 32'(wd));
        end else begin
            chk({tag, "_rdata"}, 32'(o_rdata), 32'(rd_q.pop_front()));
            chk({tag, "_no_wr_req"}, 32'(o_wr_req), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_rd_req", 32'(o_rd_req), 32'd0);
        chk("rst_wr_req", 32'(o_wr_req), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk_counters("rst", 16'd0, 16'd0);
        rst = 1'b1;

        // Cold miss, then hit, write hit and read-back.
        access("cold_rd", 1'b0, 16'h1234, 16'h0, 16'h1234, 1'b1, 12);
        chk_counters("cold", 16'd0, 16'd1);
        access("hit_rd", 1'b0, 16'h1236, 16'h0, 16'h1236, 1'b0, 0);
        chk_counters("hit", 16'd1, 16'd1);
        access("wr_hit", 1'b1, 16'h1238, 16'hBEEF, 16'h0, 1'b0, 0);
        access("wr_readback", 1'b0, 16'h1238, 16'h0, 16'hBEEF, 1'b0, 0);
        chk_counters("wr", 16'd3, 16'd1);

        // LRU eviction within set 0x23.
        access("lru_a", 1'b0, 16'h5234, 16'h0, 16'h5234, 1'b1, 12);
        access("lru_b", 1'b0, 16'h9234, 16'h0, 16'h9234, 1'b1, 12);
        access("lru_keep", 1'b0, 16'h5234, 16'h0, 16'h5234, 1'b0, 0);
        access("lru_evicted", 1'b0, 16'h1234, 16'h0, 16'h1234, 1'b1, 12);
        chk_counters("lru", 16'd4, 16'd4);

        // Write miss: allocate then write-through on replay.
        access("wr_miss", 1'b1, 16'h7002, 16'h00AA, 16'h0, 1'b1, 12);
        access("wr_miss_rd", 1'b0, 16'h7002, 16'h0, 16'h00AA, 1'b0, 0);
        chk_counters("wr_miss", 16'd5, 16'd5);

        // Idle cycles: no activity.
        repeat (3) @(negedge clk);
        #1;
        chk("idle_stall", 32'(o_stall), 32'd0);
        chk("idle_rd_req", 32'(o_rd_req), 32'd0);
        chk("idle_wr_req", 32'(o_wr_req), 32'd0);
        chk("idle_rdata", 32'(o_rdata), 32'd0);
        chk_counters("idle", 16'd5, 16'd5);

        // Reset asserted during the third returned fill word.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h3456;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 50) begin
            @(negedge clk);
            #1;
            if (o_dvalid === 1'b1) n++;
            guard++;
        end
        chk("midfill_progress", 32'(n), 32'd3);
        rst = 1'b0;
        #1;
        chk("midfill_stall", 32'(o_stall), 32'd0);
        chk("midfill_rd_req", 32'(o_rd_req), 32'd0);
        chk_counters("midfill", 16'd0, 16'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        access("post_rst", 1'b0, 16'h3456, 16'h0, 16'h3456, 1'b1, 12);
        chk_counters("post_rst", 16'd0, 16'd1);

        // Direct-mapped instance: it saw the 0x3456 miss above, then two same-index blocks conflict.
        use_dm = 1'b1;
        repeat (2) @(negedge clk);
        access("dm_a", 1'b0, 16'h1234, 16'h0, 16'h1234, 1'b1, 12);
        access("dm_b", 1'b0, 16'h5234, 16'h0, 16'h5234, 1'b1, 12);
        access("dm_evicted", 1'b0, 16'h1234, 16'h0, 16'h1234, 1'b1, 12);
        chk_counters("dm", 16'd0, 16'd4);

        repeat (12) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
